// File: rtl/prbs_checker.sv
// Serial PRBS stream checker: self-synchronises to the incoming stream, then free-runs
// a reference LFSR to flag and count bit errors, dropping lock on an error burst.
module prbs_checker #(
    parameter int                LFSR_W     = 7,
    parameter logic [LFSR_W-1:0] TAPS       = 7'h60,
    parameter int                LOCK_CNT   = 16,
    parameter int                UNLOCK_CNT = 4,
    parameter int                ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(LFSR_W);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t             state;
    logic [LFSR_W-1:0]  shreg;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    logic pred;
    logic fill_full;
    logic hunt_match;

    // A match needs a fully refilled, non-zero history so an all-zero stream can never lock.
    assign pred       = ^(shreg & TAPS);
    assign fill_full  = (fill_cnt == FILL_FULL);
    assign hunt_match = fill_full && (shreg != '0) && (in_bit == pred);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            shreg     <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        shreg <= {shreg[LFSR_W-2:0], in_bit};
                        if (!fill_full) begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                        if (hunt_match) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Shift in our own prediction so a single flipped bit costs one error only.
                        shreg <= {shreg[LFSR_W-2:0], pred};
                        if (in_bit != pred) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (miss_cnt == MISS_LAST) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                fill_cnt  <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Placed last so a clear wins over a same-cycle increment.
            if (clear_err) begin
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: a PRBS7 source drives two checker instances
// (16-bit and 4-bit error counters) and a scoreboard of expected outputs per cycle.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clear_err;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];

    // Stream source and spec-level expectation state
    logic [6:0] gen;
    bit m_locked;
    int m_hunt, m_miss, m_err16, m_err4;

    prbs_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear_err(clear_err),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear_err(clear_err),
        .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_hunt   = 0;
        m_miss   = 0;
        m_err16  = 0;
        m_err4   = 0;
    endtask

    // One clock of stimulus: flip corrupts the PRBS bit, zero sends a constant 0 instead.
    task automatic applyStimulus(input bit v, input bit flip, input bit zero, input bit clr);
        exp_t e;
        bit   b, ok, pulse;
        @(negedge clk);
        b  = 1'b0;
        ok = 1'b0;
        if (v) begin
            if (zero) begin
                b  = 1'b0;
                ok = 1'b0;
            end else begin
                gen = {gen[5:0], gen[6] ^ gen[5]};
                b   = gen[0] ^ flip;
                ok  = !flip;
            end
        end
        in_valid  = v;
        in_bit    = b;
        clear_err = clr;

        pulse = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (ok) begin
                    m_hunt++;
                    if (m_hunt == 23) begin
                        m_locked = 1'b1;
                        m_miss   = 0;
                    end
                end else begin
                    m_hunt = 0;
                end
            end else if (!ok) begin
                pulse = 1'b1;
                if (m_err16 < 65535) m_err16++;
                if (m_err4 < 15) m_err4++;
                m_miss++;
                if (m_miss == 4) begin
                    m_locked = 1'b0;
                    m_hunt   = 0;
                    m_miss   = 0;
                end
            end else begin
                m_miss = 0;
            end
        end
        if (clr) begin
            m_err16 = 0;
            m_err4  = 0;
        end
        e.locked = m_locked;
        e.pulse  = pulse;
        e.cnt16  = 16'(m_err16);
        e.cnt4   = 4'(m_err4);
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("locked",     32'(locked),     32'(e.locked));
        checkOutput("err_pulse",  32'(err_pulse),  32'(e.pulse));
        checkOutput("err_cnt",    32'(err_cnt),    32'(e.cnt16));
        checkOutput("locked4",    32'(locked4),    32'(e.locked));
        checkOutput("err_pulse4", 32'(err_pulse4), 32'(e.pulse));
        checkOutput("err_cnt4",   32'(err_cnt4),   32'(e.cnt4));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_locked",    32'(locked),    32'd0);
        checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
        checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
        checkOutput("rst_err_cnt4",  32'(err_cnt4),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_err = 1'b0;
        gen       = 7'h01;
        modelReset();
        #12;
        checkOutput("reset_locked",    32'(locked),    32'd0);
        checkOutput("reset_err_pulse", 32'(err_pulse), 32'd0);
        checkOutput("reset_err_cnt",   32'(err_cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] clean stream, continuous valid");
        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] clean stream, toggling valid");
        pulseReset();
        for (int i = 0; i < 90; i++) applyStimulus(i % 2 == 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] isolated flips while locked");
        for (int i = 1; i <= 500; i++) applyStimulus(1'b1, (i == 200) || (i == 300) || (i == 400), 1'b0, 1'b0);

        $display("[TB] reset mid-stream with err_cnt=3, then relock");
        pulseReset();
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] error burst forces unlock, relock keeps count");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] 20 isolated flips, narrow counter saturates");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] all-zero stream never locks");
        pulseReset();
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Receiving end of the team's pseudo-random stimulus stream: a serial bit-stream checker for an LFSR (PRBS) sequence.
- Self-synchronises to the incoming stream, declares lock, then free-runs its own reference LFSR.
- Flags and counts bit errors; drops lock on a burst of consecutive errors.
- Sits at the sink side of any link or datapath driven by the PRBS generator and is used as an on-chip integrity monitor.

Parameters:
LFSR_W, 7, LFSR length in bits.
TAPS, 7'h60, feedback tap mask (PRBS7, x^7+x^6+1); width LFSR_W.
LOCK_CNT, 16, consecutive matching bits required to declare lock.
UNLOCK_CNT, 4, consecutive mismatching bits in LOCKED that force a return to HUNT.
ERR_W, 16, error counter width.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  in_bit carries a stream bit this cycle.
in_bit  input  1  received serial bit.
clear_err  input  1  synchronous clear of err_cnt.
locked  output  1  checker is synchronised (registered).
err_pulse  output  1  one-cycle pulse per detected bit error (registered).
err_cnt  output  ERR_W  saturating count of errors detected while LOCKED.

Behaviour:
- Reset (async, any time, including mid-stream):
  - shreg=0, fill_cnt=0, match_cnt=0, miss_cnt=0, state=HUNT.
  - locked=0, err_pulse=0, err_cnt=0.
- Prediction:
  - pred = ^(shreg & TAPS).
  - Shift is {shreg[LFSR_W-2:0], new_bit}.
- in_valid=0: no state, counter or register change; err_pulse=0 next cycle.
- HUNT (locked=0):
  - Every valid bit shifts in_bit into shreg.
  - fill_cnt counts valid bits up to LFSR_W and saturates there.
  - A bit is a "match" only if fill_cnt==LFSR_W, shreg!=0 and in_bit==pred. Otherwise match_cnt resets to 0.
  - An all-zero stream never locks.
  - On the valid cycle producing the LOCK_CNT-th consecutive match, go to LOCKED; locked=1 from the next cycle.
  - With a clean stream from HUNT entry, lock occurs after exactly LFSR_W+LOCK_CNT valid bits.
  - No error pulses or counts in HUNT.
- LOCKED (locked=1):
  - shreg shifts in pred, not in_bit (free-running reference), so one flipped bit causes exactly one error.
  - in_bit!=pred:
    - err_pulse=1 next cycle.
    - err_cnt+1, saturating at 2^ERR_W-1.
    - miss_cnt+1.
  - in_bit==pred: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_CNT:
    - go to HUNT; locked=0 next cycle.
    - fill_cnt, match_cnt and miss_cnt cleared; shreg keeps its value but is refilled.
    - All UNLOCK_CNT errors remain counted.
- err_cnt:
  - Retains its value across unlock/relock.
  - clear_err zeroes it next cycle and has priority over a simultaneous increment: result 0, but err_pulse still fires.
- Latency: locked and err_pulse are registered outputs, 1 cycle after the valid bit that causes them.

Test Plan:
- Reset mid-stream (rst high 1 cycle while locked with err_cnt=3) -> locked=0, err_pulse=0, err_cnt=0 immediately (async); relock after 23 further valid bits.
- Clean PRBS7 stream, seed 7'h01, in_valid=1 -> locked=1 in the cycle after the 23rd bit (LFSR_W+LOCK_CNT); err_cnt=0, no err_pulse over 1000 bits.
- Same stream, in_valid toggling every cycle -> lock after 23 valid bits (45 cycles); idle cycles change nothing.
- Locked; flip bits 200, 300, 400 -> exactly 3 single-cycle err_pulse, each 1 cycle after its flipped bit; err_cnt=3; locked stays 1.
- Locked, then inverted stream for 4 bits -> err_cnt=4, locked=0 after 4th error; clean stream resumes -> relock after 23 valid bits with err_cnt still 4; clear_err coincident with a new error -> err_cnt=0, err_pulse=1.
- All-zero input for 200 bits -> locked never asserts. ERR_W=4 with 20 isolated flips while locked -> err_cnt saturates at 15.
